// File: rtl/countdown_timer.sv
// countdown_timer: tick-driven mm:ss BCD countdown
// with load/start/stop control and done/expired flags
module countdown_timer #(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       load,
   input  logic [3:0] ld_min_t,
   input  logic [3:0] ld_min_o,
   input  logic [3:0] ld_sec_t,
   input  logic [3:0] ld_sec_o,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] min_t,
   output logic [3:0] min_o,
   output logic [3:0] sec_t,
   output logic [3:0] sec_o,
   output logic       running,
   output logic       done,
   output logic       expired
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSED,
      DONE
   } state_t;

   localparam logic [7:0] PRE_MAX = 8'(TICK_DIV - 1);

   state_t     state;
   state_t     state_n;
   logic [7:0] pre;
   logic [7:0] pre_n;
   logic [3:0] mt_n;
   logic [3:0] mo_n;
   logic [3:0] st_n;
   logic [3:0] so_n;
   logic [3:0] dmt;
   logic [3:0] dmo;
   logic [3:0] dst;
   logic [3:0] dso;
   logic       exp_n;
   logic       nonzero;
   logic       dec_zero;

   function automatic logic [3:0] clamp(
      input logic [3:0] d,
      input logic [3:0] lim
   );
      return (d > lim) ? lim : d;
   endfunction

   assign nonzero  = |{min_t, min_o, sec_t, sec_o};
   assign dec_zero = ~|{dmt, dmo, dst, dso};
   assign running  = (state == RUN);
   assign done     = (state == DONE);

   // value one second lower, via the BCD borrow chain
   always_comb begin
      dso = sec_o - 4'd1;
      dst = sec_t;
      dmo = min_o;
      dmt = min_t;
      if (sec_o == 4'd0) begin
         dso = 4'd9;
         dst = sec_t - 4'd1;
         if (sec_t == 4'd0) begin
            dst = 4'd5;
            dmo = min_o - 4'd1;
            if (min_o == 4'd0) begin
               dmo = 4'd9;
               dmt = min_t - 4'd1;
            end
         end
      end
   end

   // command priority: load, then stop over start, then tick
   always_comb begin
      state_n = state;
      pre_n   = pre;
      mt_n    = min_t;
      mo_n    = min_o;
      st_n    = sec_t;
      so_n    = sec_o;
      exp_n   = 1'b0;
      if (load) begin
         mt_n    = clamp(ld_min_t, 4'd9);
         mo_n    = clamp(ld_min_o, 4'd9);
         st_n    = clamp(ld_sec_t, 4'd5);
         so_n    = clamp(ld_sec_o, 4'd9);
         pre_n   = 8'd0;
         state_n = IDLE;
      end else if (stop) begin
         if (state == RUN)
            state_n = PAUSED;
      end else if (start) begin
         if ((state == IDLE || state == PAUSED) && nonzero)
            state_n = RUN;
      end else if (tick && state == RUN) begin
         if (pre == PRE_MAX) begin
            pre_n = 8'd0;
            mt_n  = dmt;
            mo_n  = dmo;
            st_n  = dst;
            so_n  = dso;
            if (dec_zero) begin
               state_n = DONE;
               exp_n   = 1'b1;
            end
         end else begin
            pre_n = pre + 8'd1;
         end
      end
   end

   // state, prescaler, digits and expired pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pre     <= 8'd0;
         min_t   <= 4'd0;
         min_o   <= 4'd0;
         sec_t   <= 4'd0;
         sec_o   <= 4'd0;
         expired <= 1'b0;
      end else begin
         state   <= state_n;
         pre     <= pre_n;
         min_t   <= mt_n;
         min_o   <= mo_n;
         sec_t   <= st_n;
         sec_o   <= so_n;
         expired <= exp_n;
      end
   end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Tick-driven mm:ss countdown timer in BCD. It consumes the one-cycle strobe produced by the slow-clock tick generator (e.g. 1 Hz on a 24 MHz clock) and decrements a loadable minutes:seconds value once per `TICK_DIV` strobes. It provides digits for the seven-segment display path and a done indication for the application logic. It is the consumer end of the tick-strobe interface: the generator emits strobes; this block counts them.

## Interface
- `TICK_DIV`, default 1: number of `tick` strobes per one-second decrement; legal range 1–255.
- `clk` in 1: system clock. One clock only; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle strobe from the slow-clock generator, synchronous to `clk`.
- `load` in 1: one-cycle command; captures the four `ld_*` digits.
- `ld_min_t` in 4: minutes tens digit to load.
- `ld_min_o` in 4: minutes ones digit to load.
- `ld_sec_t` in 4: seconds tens digit to load.
- `ld_sec_o` in 4: seconds ones digit to load.
- `start` in 1: one-cycle command; run or resume.
- `stop` in 1: one-cycle command; pause.
- `min_t`, `min_o`, `sec_t`, `sec_o` out 4 each: current BCD value (registered).
- `running` out 1: high in RUN.
- `done` out 1: high in DONE (level).
- `expired` out 1: one-cycle pulse on reaching 00:00 from RUN.

## Operation
- States: IDLE, RUN, PAUSED, DONE. Internal prescaler `pre`, 8 bits.
- Command priority per cycle: `rst` > `load` > `start`/`stop` > `tick`. If `start` and `stop` are both high, `stop` wins.
- **`load`**, any state:
  - Digits captured. Clamp rule: any digit >9 becomes 9; `ld_sec_t` >5 becomes 5.
  - `pre` ← 0; state → IDLE; `done` clears. A simultaneous `tick` is dropped.
- **`start`** in IDLE or PAUSED with a nonzero value → RUN.
  - `start` with value 00:00 is ignored.
  - `start` in RUN or DONE is ignored.
  - A `tick` in the same cycle as an accepted `start` is not counted.
- **`stop`** in RUN → PAUSED. `pre` is retained. A same-cycle `tick` is not counted. `stop` is ignored in other states.
- **RUN, on `tick`:**
  - If `pre == TICK_DIV-1`: `pre` ← 0 and the value decrements by one second.
  - Otherwise: `pre` ← `pre`+1.
- **Decrement (BCD borrow chain):**
  - `sec_o` 0→9 with borrow, else −1.
  - `sec_t` 0→5 with borrow, else −1.
  - `min_o` 0→9 with borrow, else −1.
  - `min_t` −1.
  - Never entered at 00:00.
- If the decremented value is 00:00: state → DONE and `expired` pulses.
- DONE holds 00:00 until `load` or `rst`. `tick`, `start` and `stop` are ignored.
- IDLE and PAUSED ignore `tick`.
- Maximum value is 99:59.

## Timing
- Reset values: all digits 0, state IDLE, `pre`=0, `running`=0, `done`=0, `expired`=0.
- All outputs are registered. An event sampled at edge N is visible after edge N, with no combinational input→output path.
- A decrementing `tick` at edge N:
  - Digits show the new value from edge N.
  - On reaching zero, `expired`=1 and `done`=1 in that same cycle; `expired` drops after edge N+1.
- `running` and `done` reflect state after the same edge that changes state.
- `rst` asserted mid-RUN returns all outputs to reset values on the next edge; no `expired` pulse is produced.
- `tick` is assumed to be at most one cycle wide; a multi-cycle high counts once per cycle.

## Test plan
- **Basic countdown:** `load` 00:03, `start`, three ticks ten cycles apart → digits 00:02, 00:01, 00:00. `expired` is high exactly one cycle with the third tick; `done`=1 and `running`=0 thereafter. A fourth tick leaves the value at 00:00.
- **Borrow chain:** `load` 10:00, `start`, one tick → 09:59. `load` 01:00, `start`, tick → 00:59.
- **Pause/resume with `TICK_DIV`=4:** `load` 00:10, `start`, 3 ticks, then `stop`, then 5 ticks (ignored), then `start`, then 1 tick → 00:09. Three more ticks change nothing; the 4th tick after that → 00:08.
- **Clamp and zero start:** `load` with `ld_min_t`=12, `ld_sec_t`=7, `ld_sec_o`=10 → 90:59 (`ld_min_o`=0). `load` 00:00 then `start` → state stays IDLE, `running`=0, no `expired`.
- **Simultaneous events:**
  - In RUN at 00:05, assert `load` 00:20 together with `tick` → 00:20, IDLE, no decrement.
  - `start` + `tick` in the same cycle → no decrement until the next tick.
  - `start` + `stop` in IDLE → stays IDLE.
- **Reset mid-operation:** in RUN at 00:01, assert `rst` together with `tick` → next cycle all digits 0, IDLE, `expired`=0, `done`=0.
